// File: rtl/mbr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mbr_fetch_unit_if
// Brief    : Instruction-memory byte read bus (req/ack) for the MBR fetch unit
// Revision : 1.0 - initial release
// ============================================================================
interface mbr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mbr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : mbr_fetch_unit
// Brief    : PC/MBR owner; fetches one instruction byte per MIR fetch request
// Revision : 1.0 - initial release
// ============================================================================
module mbr_fetch_unit #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              pc_wr,
    input  wire logic [31:0]       c_bus,
    input  wire logic              fetch,
    mbr_fetch_unit_if.master       mem,
    output logic [ADDR_W-1:0]      pc,
    output logic [7:0]             MBR,
    output logic [31:0]            mbr_u,
    output logic [31:0]            mbr_s,
    output logic                   mbr_valid,
    output logic                   busy,
    output logic                   err
);

    localparam int               c_CNT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(MAX_WAIT - 1);
    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_READ = 1'b1;

    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [7:0]         r_mbr;
    logic               r_mbr_valid;
    logic               r_mem_rd;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_err;
    logic               r_pending;
    logic [ADDR_W-1:0]  r_pend_addr;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_reissue;
    logic [ADDR_W-1:0]  w_fetch_addr;

    // A PC write in the same cycle as fetch reads from the new PC
    assign w_fetch_addr = pc_wr ? c_bus[ADDR_W-1:0] : r_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_pc        <= '0;
            r_mbr       <= '0;
            r_mbr_valid <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_err       <= 1'b0;
            r_pending   <= 1'b0;
            r_pend_addr <= '0;
            r_wait_cnt  <= '0;
            r_reissue   <= 1'b0;
        end else begin
            if (pc_wr) begin
                r_pc <= c_bus[ADDR_W-1:0];
            end
            r_reissue <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (fetch) begin
                        r_mem_addr  <= w_fetch_addr;
                        r_mem_rd    <= 1'b1;
                        r_mbr_valid <= 1'b0;
                        r_wait_cnt  <= '0;
                        r_state     <= c_ST_READ;
                    end
                end
                c_ST_READ: begin
                    if (fetch && r_pending) begin
                        r_err <= 1'b1;
                    end
                    if (mem.mem_ack) begin
                        r_mbr       <= mem.mem_rdata;
                        r_mbr_valid <= 1'b1;
                        if (r_pending) begin
                            r_mem_addr <= r_pend_addr;
                            r_pending  <= 1'b0;
                            r_reissue  <= 1'b1;
                            r_wait_cnt <= '0;
                        end else if (fetch) begin
                            r_mem_addr <= w_fetch_addr;
                            r_reissue  <= 1'b1;
                            r_wait_cnt <= '0;
                        end else begin
                            r_mem_rd <= 1'b0;
                            r_state  <= c_ST_IDLE;
                        end
                    end else begin
                        // The byte just delivered goes stale one edge into the follow-on read
                        if (r_reissue) begin
                            r_mbr_valid <= 1'b0;
                        end
                        if (fetch && !r_pending) begin
                            r_pending   <= 1'b1;
                            r_pend_addr <= w_fetch_addr;
                        end
                        if (r_wait_cnt == c_LAST) begin
                            r_err     <= 1'b1;
                            r_mem_rd  <= 1'b0;
                            r_pending <= 1'b0;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign pc           = r_pc;
    assign MBR          = r_mbr;
    assign mbr_u        = {24'b0, r_mbr};
    assign mbr_s        = {{24{r_mbr[7]}}, r_mbr};
    assign mbr_valid    = r_mbr_valid;
    assign busy         = (r_state == c_ST_READ) | r_pending;
    assign err          = r_err;
    assign mem.mem_rd   = r_mem_rd;
    assign mem.mem_addr = r_mem_addr;

endmodule
`default_nettype wire

// File: tb/tb_mbr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbr_fetch_unit
// Brief    : Self-checking bench for mbr_fetch_unit with a transaction model
// Revision : 1.0 - initial release
// ============================================================================
module tb_mbr_fetch_unit;

    localparam int c_MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_wr = 1'b0;
    logic [31:0] c_bus = '0;
    logic        fetch = 1'b0;
    logic [31:0] pc;
    logic [7:0]  MBR;
    logic [31:0] mbr_u;
    logic [31:0] mbr_s;
    logic        mbr_valid;
    logic        busy;
    logic        err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc  = '0;

    mbr_fetch_unit_if #(.ADDR_W(32)) bus ();

    mbr_fetch_unit #(.ADDR_W(32), .MAX_WAIT(c_MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_wr     (pc_wr),
        .c_bus     (c_bus),
        .fetch     (fetch),
        .mem       (bus),
        .pc        (pc),
        .MBR       (MBR),
        .mbr_u     (mbr_u),
        .mbr_s     (mbr_s),
        .mbr_valid (mbr_valid),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sext8(input logic [7:0] d);
        return (d >= 8'd128) ? (32'(d) + 32'hFFFF_FF00) : 32'(d);
    endfunction

    task automatic do_reset();
        rst = 1'b0; pc_wr = 1'b0; fetch = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        step(); step();
        rst = 1'b1;
        m_pc = '0;
    endtask

    task automatic do_fetch(input bit use_wr, input logic [31:0] val);
        pc_wr = use_wr; c_bus = val; fetch = 1'b1;
        if (use_wr) m_pc = val;
        step();
        pc_wr = 1'b0; fetch = 1'b0;
    endtask

    // Serve the outstanding read: ack on request cycle waits (0-based); counts request cycles
    task automatic run_read(input int waits, input logic [7:0] data, input bit rand_pc,
                            output int cycles);
        cycles = 0;
        while (bus.mem_rd === 1'b1 && cycles < 20) begin
            bus.mem_ack   = (cycles == waits);
            bus.mem_rdata = data;
            if (rand_pc && ($urandom_range(0, 1) == 1)) begin
                pc_wr = 1'b1; c_bus = $urandom; m_pc = c_bus;
            end
            step();
            bus.mem_ack = 1'b0; pc_wr = 1'b0;
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc); end
        total++; if ({MBR, mbr_valid, bus.mem_rd, busy, err} !== 12'd0) begin
            bad++; $display("FAIL reset_state got MBR=%h v=%b rd=%b busy=%b err=%b exp all 0",
                            MBR, mbr_valid, bus.mem_rd, busy, err);
        end
        total++; if (bus.mem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    endtask

    task automatic test_single_fetch();
        int cyc;
        do_fetch(1'b1, 32'd5);
        total++; if (bus.mem_addr !== 32'd5 || bus.mem_rd !== 1'b1) begin
            bad++; $display("FAIL single_addr got addr=%h rd=%b exp addr=5 rd=1", bus.mem_addr, bus.mem_rd);
        end
        run_read(0, 8'h8F, 1'b0, cyc);
        total++; if (cyc !== 1) begin bad++; $display("FAIL single_rdcycles got=%0d exp=1", cyc); end
        total++; if (MBR !== 8'h8F || mbr_u !== 32'h0000_008F || mbr_s !== 32'hFFFF_FF8F) begin
            bad++; $display("FAIL single_mbr got MBR=%h u=%h s=%h exp 8f/0000008f/ffffff8f", MBR, mbr_u, mbr_s);
        end
        total++; if (mbr_valid !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL single_flags got v=%b busy=%b exp v=1 busy=0", mbr_valid, busy);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        pc_wr = 1'b1; c_bus = 32'h10; m_pc = 32'h10; step(); pc_wr = 1'b0;
        do_fetch(1'b0, 32'h0);
        total++; if (bus.mem_addr !== 32'h10) begin bad++; $display("FAIL wait_addr got=%h exp=10", bus.mem_addr); end
        run_read(3, 8'h42, 1'b0, cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL wait_rdcycles got=%0d exp=4", cyc); end
        total++; if (MBR !== 8'h42 || err !== 1'b0 || mbr_valid !== 1'b1) begin
            bad++; $display("FAIL wait_result got MBR=%h err=%b v=%b exp 42/0/1", MBR, err, mbr_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_fetch(1'b1, 32'd1);
        total++; if (bus.mem_addr !== 32'd1) begin bad++; $display("FAIL b2b_addr1 got=%h exp=1", bus.mem_addr); end
        do_fetch(1'b1, 32'd2);
        total++; if (busy !== 1'b1 || pc !== 32'd2 || bus.mem_addr !== 32'd1) begin
            bad++; $display("FAIL b2b_pending got busy=%b pc=%h addr=%h exp 1/2/1", busy, pc, bus.mem_addr);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11; step(); bus.mem_ack = 1'b0;
        total++; if (MBR !== 8'h11 || mbr_valid !== 1'b1 || bus.mem_addr !== 32'd2 || bus.mem_rd !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_first got MBR=%h v=%b addr=%h rd=%b busy=%b exp 11/1/2/1/1",
                            MBR, mbr_valid, bus.mem_addr, bus.mem_rd, busy);
        end
        step();
        total++; if (mbr_valid !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_gap got v=%b busy=%b exp v=0 busy=1", mbr_valid, busy);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'h22; step(); bus.mem_ack = 1'b0;
        total++; if (MBR !== 8'h22 || mbr_valid !== 1'b1 || busy !== 1'b0 || bus.mem_rd !== 1'b0) begin
            bad++; $display("FAIL b2b_second got MBR=%h v=%b busy=%b rd=%b exp 22/1/0/0",
                            MBR, mbr_valid, busy, bus.mem_rd);
        end
    endtask

    task automatic test_overrun();
        int acks;
        do_reset();
        do_fetch(1'b1, 32'h20);
        do_fetch(1'b1, 32'h21);
        do_fetch(1'b1, 32'h22);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL overrun_err got=%b exp=1", err); end
        acks = 0;
        for (int i = 0; i < 10 && bus.mem_rd === 1'b1; i++) begin
            total++; if (bus.mem_addr !== 32'h20 + 32'(acks)) begin
                bad++; $display("FAIL overrun_addr got=%h exp=%h", bus.mem_addr, 32'h20 + 32'(acks));
            end
            bus.mem_ack = 1'b1; bus.mem_rdata = 8'(acks + 1); step(); bus.mem_ack = 1'b0;
            acks++;
        end
        total++; if (acks !== 2 || MBR !== 8'd2 || busy !== 1'b0) begin
            bad++; $display("FAIL overrun_reads got reads=%0d MBR=%h busy=%b exp 2/02/0", acks, MBR, busy);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        logic [7:0] d;
        do_reset();
        d = 8'($urandom);
        do_fetch(1'b1, 32'h30);
        run_read(0, d, 1'b0, cyc);
        do_fetch(1'b1, 32'h31);
        run_read(99, 8'h00, 1'b0, cyc);
        total++; if (cyc !== c_MAX_WAIT) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", cyc, c_MAX_WAIT); end
        total++; if (err !== 1'b1 || MBR !== d || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_state got err=%b MBR=%h busy=%b exp 1/%h/0", err, MBR, busy, d);
        end
        d = ~d;
        do_fetch(1'b1, 32'h32);
        run_read(1, d, 1'b0, cyc);
        total++; if (MBR !== d || mbr_valid !== 1'b1) begin
            bad++; $display("FAIL timeout_recover got MBR=%h v=%b exp %h/1", MBR, mbr_valid, d);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        do_fetch(1'b1, 32'h7);
        rst = 1'b0; step(); rst = 1'b1; m_pc = '0;
        total++; if (bus.mem_rd !== 1'b0) begin bad++; $display("FAIL midrst_rd got=%b exp=0", bus.mem_rd); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 8'hAA; step(); bus.mem_ack = 1'b0;
        step();
        total++; if (MBR !== 8'h00 || mbr_valid !== 1'b0 || bus.mem_rd !== 1'b0 || pc !== 32'd0 || err !== 1'b0) begin
            bad++; $display("FAIL midrst_state got MBR=%h v=%b rd=%b pc=%h err=%b exp 00/0/0/0/0",
                            MBR, mbr_valid, bus.mem_rd, pc, err);
        end
    endtask

    task automatic test_random();
        int          cyc;
        int          w;
        bit          use_wr;
        logic [31:0] addr;
        logic [31:0] cv;
        logic [7:0]  d;
        do_reset();
        for (int n = 0; n < 25; n++) begin
            use_wr = ($urandom_range(0, 1) == 1);
            cv     = $urandom;
            addr   = use_wr ? cv : m_pc;
            w      = $urandom_range(0, c_MAX_WAIT - 1);
            d      = 8'($urandom);
            do_fetch(use_wr, cv);
            total++; if (bus.mem_addr !== addr || mbr_valid !== 1'b0) begin
                bad++; $display("FAIL rand_addr[%0d] got=%h v=%b exp=%h v=0", n, bus.mem_addr, mbr_valid, addr);
            end
            run_read(w, d, 1'b1, cyc);
            total++; if (cyc !== w + 1 || MBR !== d || mbr_u !== 32'(d) || mbr_s !== sext8(d) || mbr_valid !== 1'b1) begin
                bad++; $display("FAIL rand_read[%0d] got cyc=%0d MBR=%h u=%h s=%h v=%b exp cyc=%0d MBR=%h u=%h s=%h v=1",
                                n, cyc, MBR, mbr_u, mbr_s, mbr_valid, w + 1, d, 32'(d), sext8(d));
            end
            total++; if (pc !== m_pc || err !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL rand_pc[%0d] got pc=%h err=%b busy=%b exp pc=%h err=0 busy=0",
                                n, pc, err, busy, m_pc);
            end
        end
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_single_fetch();
        test_wait_states();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
